// File: rtl/histo_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the histogram sequencer.
// Frames are serialised into histo, then every bin is read back.
package histo_seq_ctrl_pkg;

  localparam int unsigned SEQ_W          = 16;
  localparam int unsigned N_BINS         = 16;
  localparam int unsigned BIN_W          = 11;
  localparam int unsigned FRAMES_PER_RUN = 5;
  localparam int unsigned RD_LAT         = 2;

  localparam int unsigned ADDR_W      = $clog2(N_BINS);
  localparam int unsigned BIT_CNT_W   = $clog2(SEQ_W);
  localparam int unsigned FRAME_CNT_W = $clog2(FRAMES_PER_RUN + 1);

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StPulse,
    StWait,
    StShift,
    StGap,
    StRead,
    StDrain
  } fsm_t;

endpackage

// File: rtl/histo_seq_ctrl_if.sv
// Bundles producer, histo and readout signals of the sequencer.
// master is the controller's view; slave is the surrounding environment.
interface histo_seq_ctrl_if;
  import histo_seq_ctrl_pkg::*;

  logic              start;
  logic              frame_valid;
  logic              frame_ready;
  logic [SEQ_W-1:0]  frame_mask;
  logic [SEQ_W-1:0]  frame_bits;
  logic              h_hist_int;
  logic              h_data_valid;
  logic              h_data_in;
  logic [ADDR_W-1:0] h_addr;
  logic [BIN_W-1:0]  h_hist_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [BIN_W-1:0]  rd_count;
  logic              rd_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, frame_valid, frame_mask, frame_bits, h_hist_data,
    output frame_ready, h_hist_int, h_data_valid, h_data_in, h_addr,
    output rd_valid, rd_addr, rd_count, rd_last, busy, done
  );

  modport slave (
    output start, frame_valid, frame_mask, frame_bits, h_hist_data,
    input  frame_ready, h_hist_int, h_data_valid, h_data_in, h_addr,
    input  rd_valid, rd_addr, rd_count, rd_last, busy, done
  );

endinterface

// File: rtl/histo_seq_ctrl_rd_pipe.sv
// Delay line matching histo's read latency: carries issue-valid, address and
// last-beat flag so they line up with the returned bin count.
module histo_seq_ctrl_rd_pipe #(
  parameter int unsigned Depth = 2,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [AddrW-1:0] in_addr,
  input  logic             in_last,
  output logic             out_valid,
  output logic [AddrW-1:0] out_addr,
  output logic             out_last
);

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] last_q;
  logic [AddrW-1:0] addr_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < Depth; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_valid & in_last;
      // Idle slots carry a zero address so rd_addr reads 0 between beats.
      addr_q[0]  <= in_valid ? in_addr : '0;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_last  = last_q[Depth-1];
  assign out_addr  = addr_q[Depth-1];

endmodule

// File: rtl/histo_seq_ctrl.sv
// Feeds FRAMES_PER_RUN frames LSB-first into histo, then sweeps all bins and
// streams (addr, count) beats downstream, ending with a one-cycle done pulse.
module histo_seq_ctrl
  import histo_seq_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst,
  histo_seq_ctrl_if.master bus
);

  fsm_t                   state_q, state_d;
  logic [SEQ_W-1:0]       mask_q, mask_d;
  logic [SEQ_W-1:0]       bits_q, bits_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   done_q;
  logic                   issue, issue_last;
  logic                   pipe_valid, pipe_last;
  logic [ADDR_W-1:0]      pipe_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      bits_q      <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      bits_q      <= bits_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      addr_q      <= addr_d;
      done_q      <= pipe_valid & pipe_last;
    end
  end

  always_comb begin
    state_d          = state_q;
    mask_d           = mask_q;
    bits_d           = bits_q;
    bit_cnt_d        = bit_cnt_q;
    frame_cnt_d      = frame_cnt_q;
    addr_d           = addr_q;
    issue            = 1'b0;
    issue_last       = 1'b0;
    bus.frame_ready  = 1'b0;
    bus.h_hist_int   = 1'b0;
    bus.h_data_valid = 1'b0;
    bus.h_data_in    = 1'b0;
    bus.h_addr       = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StAccept;
          frame_cnt_d = '0;
          addr_d      = '0;
        end
      end
      StAccept: begin
        bus.frame_ready = 1'b1;
        if (bus.frame_valid) begin
          mask_d  = bus.frame_mask;
          bits_d  = bus.frame_bits;
          state_d = StPulse;
        end
      end
      StPulse: begin
        bus.h_hist_int = 1'b1;
        state_d        = StWait;
      end
      StWait: begin
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        bus.h_data_valid = mask_q[bit_cnt_q];
        bus.h_data_in    = bits_q[bit_cnt_q];
        bit_cnt_d        = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_CNT_W'(SEQ_W - 1)) state_d = StGap;
      end
      StGap: begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (frame_cnt_q == FRAME_CNT_W'(FRAMES_PER_RUN - 1)) begin
          addr_d  = '0;
          state_d = StRead;
        end else begin
          state_d = StAccept;
        end
      end
      StRead: begin
        bus.h_addr = addr_q;
        issue      = 1'b1;
        issue_last = (addr_q == ADDR_W'(N_BINS - 1));
        if (issue_last) state_d = StDrain;
        else            addr_d  = addr_q + 1'b1;
      end
      StDrain: begin
        bus.h_addr = addr_q;
        if (done_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  histo_seq_ctrl_rd_pipe #(
    .Depth (RD_LAT),
    .AddrW (ADDR_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_addr   (addr_q),
    .in_last   (issue_last),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .out_last  (pipe_last)
  );

  assign bus.rd_valid = pipe_valid;
  assign bus.rd_addr  = pipe_addr;
  assign bus.rd_last  = pipe_last;
  assign bus.rd_count = pipe_valid ? bus.h_hist_data : '0;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_histo_seq_ctrl.sv
// Bench for histo_seq_ctrl: behavioural histo stub, a cycle-schedule model of
// the expected outputs, and directed runs with hand-computed bin counts.
module tb_histo_seq_ctrl;
  import histo_seq_ctrl_pkg::*;

  localparam int MaxCyc = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  histo_seq_ctrl_if bus ();

  histo_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // histo stand-in: bin[len]++ when a run of data_valid ends; 2-cycle read.
  int unsigned       h_bins [32];
  int unsigned       h_run;
  logic [ADDR_W-1:0] h_a1;
  logic [BIN_W-1:0]  h_rd;

  initial begin
    for (int i = 0; i < 32; i++) h_bins[i] = 0;
    h_run = 0;
    h_a1  = '0;
    h_rd  = '0;
  end

  always @(posedge clk) begin
    if (bus.h_data_valid) h_run <= h_run + 1;
    else if (h_run != 0) begin
      h_bins[h_run] <= h_bins[h_run] + 1;
      h_run         <= 0;
    end
    h_a1 <= bus.h_addr;
    h_rd <= BIN_W'(h_bins[h_a1]);
  end
  assign bus.h_hist_data = h_rd;

  // Expected outputs, scheduled per absolute cycle.
  bit               e_hint [MaxCyc];
  bit               e_dv   [MaxCyc];
  bit               e_din  [MaxCyc];
  bit               e_rdv  [MaxCyc];
  bit               e_rdl  [MaxCyc];
  bit               e_done [MaxCyc];
  bit [ADDR_W-1:0]  e_addr [MaxCyc];
  bit [ADDR_W-1:0]  e_rda  [MaxCyc];
  bit [BIN_W-1:0]   e_rdc  [MaxCyc];

  int          m_bins [32];
  bit          m_active, m_open, m_pend;
  int          m_frames, m_end, m_reopen, m_pend_c;
  logic [15:0] m_pend_mask;

  int cyc;
  int total, bad;
  int n_done, n_beats, n_dv;
  logic [BIN_W-1:0] got_cnt [N_BINS];
  int hs_cyc [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void add_runs(input logic [15:0] m, input int sgn);
    int len = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) len++;
      else if (len > 0) begin
        m_bins[len] += sgn;
        len = 0;
      end
    end
    if (len > 0) m_bins[len] += sgn;
  endfunction

  // Compare every cycle, then advance the model with this cycle's inputs.
  initial begin
    cyc = 0; total = 0; bad = 0;
    n_done = 0; n_beats = 0; n_dv = 0;
    m_active = 0; m_open = 0; m_pend = 0;
    m_frames = 0; m_end = -1; m_reopen = -1; m_pend_c = 0; m_pend_mask = '0;
    for (int i = 0; i < 32; i++) m_bins[i] = 0;
    for (int i = 0; i < N_BINS; i++) got_cnt[i] = '0;
    forever begin
      @(negedge clk);
      if (cyc + 48 >= MaxCyc) begin
        $display("FAIL cycle_budget cycle=%0d got=overflow want=<%0d", cyc, MaxCyc);
        $fatal(1);
      end
      chk("frame_ready", bus.frame_ready, m_open);
      chk("h_hist_int", bus.h_hist_int, e_hint[cyc]);
      chk("h_data_valid", bus.h_data_valid, e_dv[cyc]);
      chk("h_data_in", bus.h_data_in, e_din[cyc]);
      chk("h_addr", bus.h_addr, e_addr[cyc]);
      chk("rd_valid", bus.rd_valid, e_rdv[cyc]);
      chk("rd_addr", bus.rd_addr, e_rda[cyc]);
      chk("rd_count", bus.rd_count, e_rdc[cyc]);
      chk("rd_last", bus.rd_last, e_rdl[cyc]);
      chk("busy", bus.busy, m_active);
      chk("done", bus.done, e_done[cyc]);
      if (bus.done === 1'b1) n_done++;
      if (bus.h_data_valid === 1'b1) n_dv++;
      if (bus.rd_valid === 1'b1) begin
        n_beats++;
        got_cnt[bus.rd_addr] = bus.rd_count;
      end

      if (rst) begin
        // A frame cut short still leaves its emitted prefix in histo.
        if (m_pend && cyc < m_pend_c + 18) begin
          int n;
          n = cyc - (m_pend_c + 3) + 1;
          if (n < 0) n = 0;
          add_runs(m_pend_mask, -1);
          add_runs(m_pend_mask & 16'((32'd1 << n) - 1), 1);
        end
        for (int k = cyc + 1; k < MaxCyc; k++) begin
          e_hint[k] = 0; e_dv[k] = 0; e_din[k] = 0; e_rdv[k] = 0; e_rdl[k] = 0;
          e_done[k] = 0; e_addr[k] = '0; e_rda[k] = '0; e_rdc[k] = '0;
        end
        m_active = 0; m_open = 0; m_pend = 0; m_end = -1; m_reopen = -1;
      end else begin
        if (!m_active && bus.start) begin
          m_active = 1; m_open = 1; m_frames = 0; m_end = -1; m_reopen = -1;
        end else if (m_open && bus.frame_valid) begin
          m_open      = 0;
          m_pend      = 1;
          m_pend_c    = cyc;
          m_pend_mask = bus.frame_mask;
          m_frames++;
          add_runs(bus.frame_mask, 1);
          e_hint[cyc+1] = 1;
          for (int i = 0; i < 16; i++) begin
            e_dv[cyc+3+i]  = bus.frame_mask[i];
            e_din[cyc+3+i] = bus.frame_bits[i];
          end
          if (m_frames == FRAMES_PER_RUN) begin
            for (int k = 0; k < N_BINS; k++) begin
              e_addr[cyc+20+k] = ADDR_W'(k);
              e_rdv[cyc+22+k]  = 1;
              e_rda[cyc+22+k]  = ADDR_W'(k);
              e_rdc[cyc+22+k]  = BIN_W'(m_bins[k]);
            end
            e_rdl[cyc+37]  = 1;
            e_addr[cyc+36] = ADDR_W'(N_BINS - 1);
            e_addr[cyc+37] = ADDR_W'(N_BINS - 1);
            e_addr[cyc+38] = ADDR_W'(N_BINS - 1);
            e_done[cyc+38] = 1;
            m_end = cyc + 38;
          end else begin
            m_reopen = cyc + 19;
          end
        end
        if (m_active && cyc == m_end) m_active = 0;
        if (cyc == m_reopen) m_open = 1;
      end
      cyc++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] m, input logic [15:0] b, input bit hold,
                            output int hs);
    bit got = 0;
    hs = -1;
    bus.frame_valid = 1'b1;
    bus.frame_mask  = m;
    bus.frame_bits  = b;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.frame_ready) begin
        got = 1;
        hs  = cyc;
      end
      tick();
    end
    chk("handshake_seen", got, 1);
    if (!hold) bus.frame_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (bus.done) got = 1;
      tick();
    end
    chk("done_seen", got, 1);
    tick(2);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run5(input logic [15:0] ms [5], input logic [15:0] b, input bit hold,
                      input bit poke_busy);
    int hs;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send_frame(ms[i], b, hold, hs);
      hs_cyc[i] = hs;
      if (poke_busy && i == 2) pulse_start();
    end
    bus.frame_valid = 1'b0;
    wait_done();
  endtask

  logic [15:0] m1 [5] = '{16'h000C, 16'h0070, 16'h0010, 16'h00FF, 16'h00C0};
  logic [15:0] m3 [5] = '{16'h0101, 16'h0F00, 16'h3000, 16'h0003, 16'h0500};
  logic [15:0] mz [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] m6 [5] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001};

  initial begin
    int hs;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.frame_valid = 1'b0;
    bus.frame_mask = '0;
    bus.frame_bits = '0;
    tick(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_ready", bus.frame_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    rst = 1'b0;
    tick(2);

    // Accumulating run with frame_valid held and a stray start mid-run.
    n_done = 0; n_beats = 0;
    run5(m1, 16'h0000, 1, 1);
    for (int i = 0; i < 4; i++) chk("frame_spacing", hs_cyc[i+1] - hs_cyc[i], 20);
    chk("t1_done_count", n_done, 1);
    chk("t1_beats", n_beats, 16);
    chk("t1_bin0", got_cnt[0], 0);
    chk("t1_bin1", got_cnt[1], 1);
    chk("t1_bin2", got_cnt[2], 2);
    chk("t1_bin3", got_cnt[3], 1);
    chk("t1_bin4", got_cnt[4], 0);
    chk("t1_bin8", got_cnt[8], 1);
    chk("t1_model_bin2", m_bins[2], 2);
    chk("t1_idle_after", bus.busy, 0);

    // Start with no frame offered: frame_ready stays up.
    pulse_start();
    tick(5);
    chk("ready_held", bus.frame_ready, 1);
    for (int i = 0; i < 5; i++) send_frame(m3[i], 16'hA5C3, 0, hs);
    wait_done();

    // Reset in the middle of frame 3's shift aborts the run.
    pulse_start();
    send_frame(16'h0001, 16'h0000, 0, hs);
    send_frame(16'h0001, 16'h0000, 0, hs);
    send_frame(16'h00FF, 16'h0000, 0, hs);
    tick(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_dv", bus.h_data_valid, 0);
    chk("abort_ready", bus.frame_ready, 0);
    n_done = 0; n_beats = 0;
    tick(40);
    chk("abort_no_beats", n_beats, 0);
    chk("abort_no_done", n_done, 0);
    run5(m1, 16'h0000, 1, 0);
    chk("fresh_done_count", n_done, 1);
    chk("fresh_beats", n_beats, 16);

    // Empty masks, then two single-bit runs per frame.
    n_dv = 0;
    run5(mz, 16'hFFFF, 0, 0);
    chk("zero_mask_dv", n_dv, 0);
    run5(m6, 16'h0000, 1, 0);
    chk("end_bin1", got_cnt[1], 18);
    chk("end_bin2", got_cnt[2], 6);
    chk("end_bin3", got_cnt[3], 2);
    chk("end_bin4", got_cnt[4], 1);
    chk("end_bin5", got_cnt[5], 1);
    chk("end_bin8", got_cnt[8], 2);
    chk("end_bin15", got_cnt[15], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cycle=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule
